panel_ctrl: RTL

PANEL_CTRL -- requirements
Module: panel_ctrl

---
 rtl/panel_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/panel_ctrl.sv
// panel_ctrl: front-panel controller.
//   - KEYS debounced keys with press events, optional hold/auto-repeat.
//   - DIGITS multiplexed 7-segment digits with a per-frame latch,
//     an anti-ghost blank and per-digit flashing.
// Build option: define PANEL_AUTOREPEAT_EN to enable the hold counters,
// key_rep_o and key_held_o. Without it those outputs are tied low and the
// debounce and display logic is unchanged.
// Handshake: none. key_evt_o/key_rep_o are single-cycle registered pulses,
// key_held_o is a level. key_state_o exposes each key FSM (2 bits per key).
module panel_ctrl #(
   parameter int DIGITS    = 5,
   parameter int KEYS      = 5,
   parameter int DEB_CYC   = 200000,
   parameter int HOLD_CYC  = 10000000,
   parameter int REP_CYC   = 2000000,
   parameter int SCAN_CYC  = 20000,
   parameter int FLASH_CYC = 5000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [KEYS-1:0]       key_raw_i,
   input  logic [DIGITS*8-1:0]   disp_data_i,
   input  logic [DIGITS-1:0]     flash_mask_i,
   output logic [DIGITS-1:0]     seg_sel_o,
   output logic [7:0]            seg_out_o,
   output logic [KEYS-1:0]       key_evt_o,
   output logic [KEYS-1:0]       key_rep_o,
   output logic [KEYS-1:0]       key_held_o,
   output logic [2*KEYS-1:0]     key_state_o
);

   localparam int DEB_W   = $clog2(DEB_CYC + 1);
   localparam int SCAN_W  = $clog2(SCAN_CYC + 1);
   localparam int FLASH_W = $clog2(FLASH_CYC + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int HOLD_W  = $clog2(CNT_MAX + 1);

   if (DEB_CYC < 2 || HOLD_CYC < 1 || REP_CYC < 1 || SCAN_CYC < 1 || FLASH_CYC < 1
       || HOLD_W < 1) begin : g_param_err
      $error("panel_ctrl: illegal timing parameter");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, DEB_PRESS = 2'd1, PRESSED = 2'd2, DEB_REL = 2'd3} key_state_e;

   logic [KEYS-1:0]  sync1_q, sync2_q;
   key_state_e       state_q [KEYS];
   key_state_e       state_d [KEYS];
   logic [DEB_W-1:0] deb_q   [KEYS];
   logic [DEB_W-1:0] deb_d   [KEYS];
   logic [KEYS-1:0]  evt_q, evt_d;

   // Two-flop synchroniser on every raw key level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= key_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Key FSM state, debounce counters and the registered press pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < KEYS; i++) begin
            state_q[i] <= IDLE;
            deb_q[i]   <= '0;
         end
         evt_q <= '0;
      end else begin
         for (int i = 0; i < KEYS; i++) begin
            state_q[i] <= state_d[i];
            deb_q[i]   <= deb_d[i];
         end
         evt_q <= evt_d;
      end
   end

   // Next state: the IDLE/PRESSED cycle that first sees the new level counts
   // as the first stable clock, so the counter enters DEB_* at 1.
   always_comb begin
      for (int i = 0; i < KEYS; i++) begin
         state_d[i] = state_q[i];
         deb_d[i]   = deb_q[i];
         case (state_q[i])
            IDLE: begin
               if (sync2_q[i]) begin
                  state_d[i] = DEB_PRESS;
                  deb_d[i]   = DEB_W'(1);
               end
            end
            DEB_PRESS: begin
               if (!sync2_q[i]) begin
                  state_d[i] = IDLE;
                  deb_d[i]   = '0;
               end else if (deb_q[i] == DEB_W'(DEB_CYC - 1)) begin
                  state_d[i] = PRESSED;
                  deb_d[i]   = '0;
               end else begin
                  deb_d[i] = deb_q[i] + DEB_W'(1);
               end
            end
            PRESSED: begin
               if (!sync2_q[i]) begin
                  state_d[i] = DEB_REL;
                  deb_d[i]   = DEB_W'(1);
               end
            end
            DEB_REL: begin
               if (sync2_q[i]) begin
                  state_d[i] = PRESSED;
                  deb_d[i]   = '0;
               end else if (deb_q[i] == DEB_W'(DEB_CYC - 1)) begin
                  state_d[i] = IDLE;
                  deb_d[i]   = '0;
               end else begin
                  deb_d[i] = deb_q[i] + DEB_W'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               deb_d[i]   = '0;
            end
         endcase
      end
   end

   // FSM outputs: press pulse on the DEB_PRESS->PRESSED transition, debug state.
   always_comb begin
      evt_d       = '0;
      key_state_o = '0;
      for (int i = 0; i < KEYS; i++) begin
         evt_d[i]             = (state_q[i] == DEB_PRESS) && (state_d[i] == PRESSED);
         key_state_o[2*i +: 2] = state_q[i];
      end
   end

   assign key_evt_o = evt_q;

`ifdef PANEL_AUTOREPEAT_EN
   logic [HOLD_W-1:0] hold_q [KEYS];
   logic [HOLD_W-1:0] hold_d [KEYS];
   logic [KEYS-1:0]   rep_q, rep_d, held_q, held_d, pressed_v;
   logic              multi;

   // Several keys down at once is treated as a chord: repeat is frozen.
   always_comb begin
      pressed_v = '0;
      for (int i = 0; i < KEYS; i++) pressed_v[i] = (state_q[i] == PRESSED);
      multi = ($countones(pressed_v) > 1);
   end

   // Hold counter: first repeat after HOLD_CYC, then every REP_CYC; cleared on IDLE entry.
   always_comb begin
      rep_d  = '0;
      held_d = held_q;
      for (int i = 0; i < KEYS; i++) begin
         hold_d[i] = hold_q[i];
         if (state_d[i] == IDLE) begin
            hold_d[i] = '0;
            held_d[i] = 1'b0;
         end else if ((state_q[i] == PRESSED || state_q[i] == DEB_REL) && !multi) begin
            if (!held_q[i] && hold_q[i] == HOLD_W'(HOLD_CYC - 1)) begin
               rep_d[i]  = 1'b1;
               held_d[i] = 1'b1;
               hold_d[i] = '0;
            end else if (held_q[i] && hold_q[i] == HOLD_W'(REP_CYC - 1)) begin
               rep_d[i]  = 1'b1;
               hold_d[i] = '0;
            end else begin
               hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
         end
      end
   end

   // Hold/repeat registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < KEYS; i++) hold_q[i] <= '0;
         rep_q  <= '0;
         held_q <= '0;
      end else begin
         for (int i = 0; i < KEYS; i++) hold_q[i] <= hold_d[i];
         rep_q  <= rep_d;
         held_q <= held_d;
      end
   end

   assign key_rep_o  = rep_q;
   assign key_held_o = held_q;
`else
   assign key_rep_o  = '0;
   assign key_held_o = '0;
`endif

   logic                run_q;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                latch;
   logic [FLASH_W-1:0]  flash_q, flash_d;
   logic                phase_q, phase_d;
   logic [DIGITS*8-1:0] frame_data_q;
   logic [DIGITS-1:0]   frame_mask_q;

   // Scan/flash sequencing; the first edge after reset starts digit 0 and
   // counts as a frame start so the frame register is loaded immediately.
   always_comb begin
      scan_d  = scan_q;
      idx_d   = idx_q;
      latch   = 1'b0;
      flash_d = flash_q + FLASH_W'(1);
      phase_d = phase_q;
      if (!run_q) begin
         scan_d = '0;
         idx_d  = '0;
         latch  = 1'b1;
      end else if (scan_q == SCAN_W'(SCAN_CYC - 1)) begin
         scan_d = '0;
         if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_d = '0;
            latch = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         scan_d = scan_q + SCAN_W'(1);
      end
      if (flash_q == FLASH_W'(FLASH_CYC - 1)) begin
         flash_d = '0;
         phase_d = !phase_q;
      end
   end

   // Display registers, including the once-per-frame snapshot of the inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q        <= 1'b0;
         scan_q       <= '0;
         idx_q        <= '0;
         flash_q      <= '0;
         phase_q      <= 1'b1;
         frame_data_q <= '0;
         frame_mask_q <= '0;
      end else begin
         run_q   <= 1'b1;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         flash_q <= flash_d;
         phase_q <= phase_d;
         if (latch) begin
            frame_data_q <= disp_data_i;
            frame_mask_q <= flash_mask_i;
         end
      end
   end

   // Digit drive: blank in the first clock of a slot and for flashing digits in the off phase.
   always_comb begin
      seg_sel_o = '0;
      seg_out_o = 8'h00;
      if (run_q) begin
         seg_sel_o = DIGITS'(1) << idx_q;
         if (scan_q != '0 && !(!phase_q && frame_mask_q[idx_q]))
            seg_out_o = frame_data_q[8*int'(idx_q) +: 8];
      end
   end

endmodule
